// File: rtl/count_ifc_test.sv
// BCD decade counter stage (0-9) with synchronous master reset, parallel load and count enable.
// Define COUNT_IFC_TEST_UPDOWN_EN to add the Dir input for down counting (0 -> 9 wrap).
module count_ifc_test (
  input  logic       CLK,
  input  logic       MR,
  input  logic       Load,
  input  logic       Enable,
`ifdef COUNT_IFC_TEST_UPDOWN_EN
  input  logic       Dir,
`endif
  input  logic [3:0] P,
  output logic [3:0] Q,
  output logic       TC
);

  logic [3:0] q_reg;
  logic [3:0] q_next;
  logic [3:0] q_inc;
  logic [4:0] inc_sum;
  logic       count_down;

`ifdef COUNT_IFC_TEST_UPDOWN_EN
  assign count_down = Dir;
`else
  assign count_down = 1'b0;
`endif

  // Widened sum spans 1..16, so one conditional subtract of 10 is a full mod-10
  // reduction; this is what lets out-of-range loads (10..15) land on 1..6.
  always_comb begin
    inc_sum = {1'b0, q_reg} + 5'd1;
    q_inc   = inc_sum[3:0];
    if (inc_sum >= 5'd10) begin
      q_inc = 4'(inc_sum - 5'd10);
    end
  end

  always_comb begin
    q_next = q_reg;
    if (MR) begin
      q_next = 4'd0;
    end else if (Load) begin
      q_next = P;
    end else if (Enable) begin
      if (count_down) begin
        q_next = (q_reg == 4'd0) ? 4'd9 : (q_reg - 4'd1);
      end else begin
        q_next = q_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    q_reg <= q_next;
  end

  assign Q = q_reg;

  // Combinational so a chained next stage sees its enable in the same cycle.
  assign TC = Enable && (count_down ? (q_reg == 4'd0) : (q_reg == 4'd9));

endmodule

// File: tb/tb_count_ifc_test.sv
// Self-checking bench for count_ifc_test: a reference model pushes the expected Q per edge
// into a scoreboard queue, popped and compared after each rising edge.
module tb_count_ifc_test;

  logic       CLK = 1'b0;
  logic       MR = 1'b0;
  logic       Load = 1'b0;
  logic       Enable = 1'b0;
  logic       Dir = 1'b0;
  logic [3:0] P = 4'd0;
  logic [3:0] Q;
  logic       TC;

  int n_checks = 0;
  int n_pass = 0;
  int model_q = 0;
  int exp_q_fifo[$];

  count_ifc_test dut (
    .CLK    (CLK),
    .MR     (MR),
    .Load   (Load),
    .Enable (Enable),
`ifdef COUNT_IFC_TEST_UPDOWN_EN
    .Dir    (Dir),
`endif
    .P      (P),
    .Q      (Q),
    .TC     (TC)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, model the edge, compare Q and TC just after it.
  task automatic step(input string tag, input logic mr, input logic ld, input logic en,
                      input int p, input logic dir);
    int exp_q;
    int exp_tc;
    @(negedge CLK);
    MR = mr; Load = ld; Enable = en; P = 4'(p); Dir = dir;
    if (mr)       model_q = 0;
    else if (ld)  model_q = p;
    else if (en) begin
`ifdef COUNT_IFC_TEST_UPDOWN_EN
      if (dir) model_q = (model_q == 0) ? 9 : model_q - 1;
      else     model_q = (model_q + 1) % 10;
`else
      model_q = (model_q + 1) % 10;
`endif
    end
    exp_q_fifo.push_back(model_q);
    @(posedge CLK);
    #1;
    if (exp_q_fifo.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      exp_q = exp_q_fifo.pop_front();
      check({tag, "_q"}, int'(Q), exp_q);
`ifdef COUNT_IFC_TEST_UPDOWN_EN
      exp_tc = (en && (dir ? (exp_q == 0) : (exp_q == 9))) ? 1 : 0;
`else
      exp_tc = (en && exp_q == 9) ? 1 : 0;
`endif
      check({tag, "_tc"}, int'(TC), exp_tc);
    end
    $display("step %-10s mr=%0b ld=%0b en=%0b dir=%0b p=%0d -> Q=%0d TC=%0b",
             tag, mr, ld, en, dir, p, Q, TC);
  endtask

  initial begin
    // Reset wins over load and enable; Q cleared after first edge and stays 0.
    step("reset", 1, 1, 1, 7, 0);
    step("reset", 1, 1, 1, 7, 0);

    for (int i = 0; i < 12; i++) step("count", 0, 0, 1, 0, 0);

    step("ld4", 0, 1, 0, 4, 0);
    step("ldprio", 0, 1, 1, 8, 0);
    step("cnt9", 0, 0, 1, 0, 0);
    step("wrap", 0, 0, 1, 0, 0);

    step("ld5", 0, 1, 0, 5, 0);
    for (int i = 0; i < 5; i++) step("hold", 0, 0, 0, 3, 0);

    for (int v = 10; v < 16; v++) begin
      step("oor_ld", 0, 1, 0, v, 0);
      step("oor_tc", 0, 0, 0, 0, 0);
      step("oor_inc", 0, 0, 1, 0, 0);
    end

    step("ld9", 0, 1, 0, 9, 0);
    step("tc_noen", 0, 0, 0, 0, 0);
    step("ld6", 0, 1, 0, 6, 0);
    step("midcnt", 0, 0, 1, 0, 0);
    step("midrst", 1, 0, 1, 0, 0);
    step("resume", 0, 0, 1, 0, 0);

`ifdef COUNT_IFC_TEST_UPDOWN_EN
    step("ld2", 0, 1, 0, 2, 1);
    step("down1", 0, 0, 1, 0, 1);
    step("down0", 0, 0, 1, 0, 1);
    step("down9", 0, 0, 1, 0, 1);
    step("dnrst", 1, 0, 1, 0, 1);
    step("ld15", 0, 1, 1, 15, 1);
    step("down14", 0, 0, 1, 0, 1);
`endif

    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
